ray_march_sequencer: RTL and testbench

//   Per-frame ray-march controller for the player direction ray overlay.
//   On each frame_start it latches player position and direction vector, then

---
 rtl/ray_pkg.sv | 23 ++
 rtl/ray_march_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_ray_march_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ray_pkg.sv
// ray_pkg
//   Shared types and constants for the ray-march sequencer.
//   state_t : sequencer FSM states
//   COL_*   : RGB444 result colours written into hit_color
//   POS_W   : width of the signed fixed-point march position
package ray_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        REQ,
        STEP,
        DONE
    } state_t;

    localparam logic [11:0] COL_WALL = 12'hF00;
    localparam logic [11:0] COL_MISS = 12'h0F0;
    localparam logic [11:0] COL_OOB  = 12'hFF0;

    // {sign, 10 integer bits, 4 fractional bits}
    localparam int POS_W = 15;

endpackage

// File: rtl/ray_march_sequencer.sv
// ray_march_sequencer
//   Per-frame ray-march controller for the player direction overlay. On
//   frame_start it latches the player position and direction vector, then
//   walks a fixed-point point along the vector in vec/2**FRAC_BITS pixel
//   steps, querying the wall map at every point over a req/ack handshake.
//   The terminating point, step index and colour are held on hitX/hitY/
//   hit_steps/hit_color until the next march finishes.
//
// Ports
//   Clk, Reset_n          clock, synchronous active-low reset
//   frame_start           one-cycle start pulse, ignored while busy
//   X, Y                  player centre in pixels (unsigned)
//   x_vec, y_vec          direction vector (two's complement)
//   map_req               tile lookup request
//   map_tile_x/y          tile column/row of the current point
//   map_ack, map_wall     lookup complete / tile is a wall (same cycle)
//   busy                  high whenever the FSM is not IDLE
//   hit_valid             one-cycle pulse while a new result is presented
//   hitX, hitY            integer pixel of the terminating point
//   hit_steps             index of the terminating step
//   hit_color             RGB444 result colour
module ray_march_sequencer
    import ray_pkg::*;
#(
    parameter int FRAC_BITS  = 4,
    parameter int MAX_STEPS  = 16,
    parameter int TILE_SHIFT = 5,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           frame_start,
    input  logic [9:0]                     X,
    input  logic [9:0]                     Y,
    input  logic [7:0]                     x_vec,
    input  logic [7:0]                     y_vec,
    output logic                           map_req,
    output logic [9-TILE_SHIFT:0]          map_tile_x,
    output logic [9-TILE_SHIFT:0]          map_tile_y,
    input  logic                           map_ack,
    input  logic                           map_wall,
    output logic                           busy,
    output logic                           hit_valid,
    output logic [9:0]                     hitX,
    output logic [9:0]                     hitY,
    output logic [$clog2(MAX_STEPS+1)-1:0] hit_steps,
    output logic [11:0]                    hit_color
);

    localparam int PW     = FRAC_BITS + 11;
    localparam int STEP_W = $clog2(MAX_STEPS + 1);

    localparam logic [9:0]        X_LIM    = 10'(SCREEN_W);
    localparam logic [9:0]        Y_LIM    = 10'(SCREEN_H);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS);

    state_t              state_q, state_d;
    logic [PW-1:0]       pos_x_q, pos_x_d;
    logic [PW-1:0]       pos_y_q, pos_y_d;
    logic [7:0]          vec_x_q, vec_x_d;
    logic [7:0]          vec_y_q, vec_y_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [9:0]          hit_x_q, hit_x_d;
    logic [9:0]          hit_y_q, hit_y_d;
    logic [STEP_W-1:0]   hit_steps_q, hit_steps_d;
    logic [11:0]         hit_color_q, hit_color_d;

    logic [9:0]          int_x, int_y;
    logic                oob;
    logic                load_hit;
    logic [11:0]         res_color;

    // Integer pixel of the current point; no saturation, so a negative
    // position shows up as a large value here and is caught by the sign bit.
    assign int_x = pos_x_q[FRAC_BITS+9 -: 10];
    assign int_y = pos_y_q[FRAC_BITS+9 -: 10];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        vec_x_d     = vec_x_q;
        vec_y_d     = vec_y_q;
        step_d      = step_q;
        hit_x_d     = hit_x_q;
        hit_y_d     = hit_y_q;
        hit_steps_d = hit_steps_q;
        hit_color_d = hit_color_q;
        map_req     = 1'b0;
        load_hit    = 1'b0;
        res_color   = COL_MISS;

        oob = pos_x_q[PW-1] || pos_y_q[PW-1] || (int_x >= X_LIM) || (int_y >= Y_LIM);

        unique case (state_q)
            IDLE: begin
                if (frame_start) state_d = LATCH;
            end
            LATCH: begin
                pos_x_d = {1'b0, X, {FRAC_BITS{1'b0}}};
                pos_y_d = {1'b0, Y, {FRAC_BITS{1'b0}}};
                vec_x_d = x_vec;
                vec_y_d = y_vec;
                step_d  = '0;
                state_d = REQ;
            end
            REQ: begin
                // An off-screen point terminates without touching the map.
                if (oob) begin
                    load_hit  = 1'b1;
                    res_color = COL_OOB;
                end else begin
                    map_req = 1'b1;
                    if (map_ack) begin
                        if (map_wall) begin
                            load_hit  = 1'b1;
                            res_color = COL_WALL;
                        end else if (step_q == LAST_STEP) begin
                            load_hit  = 1'b1;
                            res_color = COL_MISS;
                        end else begin
                            state_d = STEP;
                        end
                    end
                end
            end
            STEP: begin
                pos_x_d = pos_x_q + {{(PW-8){vec_x_q[7]}}, vec_x_q};
                pos_y_d = pos_y_q + {{(PW-8){vec_y_q[7]}}, vec_y_q};
                step_d  = step_q + STEP_W'(1);
                state_d = REQ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Result registers load on the transition into DONE so they are
        // already valid during the hit_valid cycle.
        if (load_hit) begin
            state_d     = DONE;
            hit_x_d     = int_x;
            hit_y_d     = int_y;
            hit_steps_d = step_q;
            hit_color_d = res_color;
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge value of the others, independent of statement order.
        if (!Reset_n) begin
            state_q     <= IDLE;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            vec_x_q     <= '0;
            vec_y_q     <= '0;
            step_q      <= '0;
            hit_x_q     <= '0;
            hit_y_q     <= '0;
            hit_steps_q <= '0;
            hit_color_q <= '0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            vec_x_q     <= vec_x_d;
            vec_y_q     <= vec_y_d;
            step_q      <= step_d;
            hit_x_q     <= hit_x_d;
            hit_y_q     <= hit_y_d;
            hit_steps_q <= hit_steps_d;
            hit_color_q <= hit_color_d;
        end
    end

    assign map_tile_x = int_x[9:TILE_SHIFT];
    assign map_tile_y = int_y[9:TILE_SHIFT];
    assign busy       = (state_q != IDLE);
    assign hit_valid  = (state_q == DONE);
    assign hitX       = hit_x_q;
    assign hitY       = hit_y_q;
    assign hit_steps  = hit_steps_q;
    assign hit_color  = hit_color_q;

endmodule

// File: tb/tb_ray_march_sequencer.sv
// Testbench for ray_march_sequencer: a table of march scenarios with
// hand-computed results, plus hand-written frame_start-while-busy and
// reset-mid-march sequences. A responder models the wall map with a single
// wall tile at (4,3) and a programmable ack delay.
module tb_ray_march_sequencer;

    localparam int MARCH_WINDOW = 60;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_start;
    logic [9:0] X, Y;
    logic [7:0] x_vec, y_vec;
    logic       map_req;
    logic [4:0] map_tile_x, map_tile_y;
    logic       map_ack  = 1'b0;
    logic       map_wall = 1'b0;
    logic       busy;
    logic       hit_valid;
    logic [9:0] hitX, hitY;
    logic [4:0] hit_steps;
    logic [11:0] hit_color;

    ray_march_sequencer dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_start(frame_start),
        .X          (X),
        .Y          (Y),
        .x_vec      (x_vec),
        .y_vec      (y_vec),
        .map_req    (map_req),
        .map_tile_x (map_tile_x),
        .map_tile_y (map_tile_y),
        .map_ack    (map_ack),
        .map_wall   (map_wall),
        .busy       (busy),
        .hit_valid  (hit_valid),
        .hitX       (hitX),
        .hitY       (hitY),
        .hit_steps  (hit_steps),
        .hit_color  (hit_color)
    );

    always #5 Clk = ~Clk;

    int n_vectors = 0;
    int n_miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vectors++;
        if (act != exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- wall-map responder ----------------
    bit         wall_en   = 1'b0;
    int         ack_delay = 0;
    int         req_cycles   = 0;
    int         tile_changes = 0;
    int         wait_cnt  = 0;
    bit         in_lookup = 1'b0;
    logic [4:0] last_tx = '0, last_ty = '0;

    always @(negedge Clk) begin
        if (map_req) begin
            req_cycles++;
            if (in_lookup && (map_tile_x != last_tx || map_tile_y != last_ty)) tile_changes++;
            last_tx = map_tile_x;
            last_ty = map_tile_y;
            if (wait_cnt == ack_delay) begin
                map_ack   = 1'b1;
                map_wall  = wall_en && (map_tile_x == 5'd4) && (map_tile_y == 5'd3);
                wait_cnt  = 0;
                in_lookup = 1'b0;
            end else begin
                map_ack   = 1'b0;
                map_wall  = 1'b0;
                wait_cnt++;
                in_lookup = 1'b1;
            end
        end else begin
            map_ack   = 1'b0;
            map_wall  = 1'b0;
            wait_cnt  = 0;
            in_lookup = 1'b0;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [7:0]  xv;
        logic [7:0]  yv;
        int          delay;
        bit          wall;
        int          cyc;
        int          ex;
        int          ey;
        int          es;
        logic [11:0] ec;
        int          reqs;
    } vec_t;

    vec_t vecs[10];

    // Runs one march starting right after a posedge (+#1); frame_start is
    // sampled at the next edge (cycle 0). Optionally re-pulses frame_start
    // during cycle fs_again to confirm it is ignored.
    task automatic apply_vec(input vec_t v, input int fs_again, input string tag);
        int first_cyc, n_valid, base_req, base_chg;
        int got_x, got_y, got_s, got_c;
        wall_en   = v.wall;
        ack_delay = v.delay;
        base_req  = req_cycles;
        base_chg  = tile_changes;
        first_cyc = -1;
        n_valid   = 0;
        got_x = 0; got_y = 0; got_s = 0; got_c = 0;
        X = v.x; Y = v.y; x_vec = v.xv; y_vec = v.yv;
        frame_start = 1'b1;
        @(posedge Clk);
        #1 frame_start = 1'b0;
        for (int c = 1; c <= MARCH_WINDOW; c++) begin
            if (c == fs_again) frame_start = 1'b1;
            // Inputs are only latched in cycle 1; scramble them afterwards.
            if (c == 2) begin
                X = 10'h3FF; Y = 10'h155; x_vec = 8'h7F; y_vec = 8'h81;
            end
            @(negedge Clk);
            if (hit_valid) begin
                n_valid++;
                if (first_cyc < 0) begin
                    first_cyc = c;
                    got_x = hitX; got_y = hitY; got_s = hit_steps; got_c = hit_color;
                end
            end
            @(posedge Clk);
            #1 frame_start = 1'b0;
        end
        check({tag, " hit_valid cycle"}, first_cyc, v.cyc);
        check({tag, " hit_valid count"}, n_valid, 1);
        check({tag, " hitX"}, got_x, v.ex);
        check({tag, " hitY"}, got_y, v.ey);
        check({tag, " hit_steps"}, got_s, v.es);
        check({tag, " hit_color"}, got_c, int'(v.ec));
        check({tag, " map_req cycles"}, req_cycles - base_req, v.reqs);
        check({tag, " tile changes during wait"}, tile_changes - base_chg, 0);
        @(negedge Clk);
        check({tag, " busy after march"}, int'(busy), 0);
        check({tag, " hitX persists"}, int'(hitX), v.ex);
        check({tag, " hit_color persists"}, int'(hit_color), int'(v.ec));
        @(posedge Clk);
        #1;
    endtask

    initial begin
        //             x    y    xv     yv     dly wall cyc  ex    ey   es  colour   reqs
        vecs[0] = '{10'd100, 10'd100, 8'd64,  8'd0,   0, 1'b0, 35, 164,  100, 16, 12'h0F0, 17};
        vecs[1] = '{10'd100, 10'd100, 8'd64,  8'd0,   0, 1'b1, 17, 128,  100, 7,  12'hF00, 8};
        vecs[2] = '{10'd2,   10'd50,  8'hC0,  8'd0,   0, 1'b0, 5,  1022, 50,  1,  12'hFF0, 1};
        vecs[3] = '{10'd100, 10'd100, 8'd64,  8'd0,   3, 1'b1, 41, 128,  100, 7,  12'hF00, 32};
        vecs[4] = '{10'd300, 10'd200, 8'd0,   8'd0,   0, 1'b1, 35, 300,  200, 16, 12'h0F0, 17};
        vecs[5] = '{10'd10,  10'd470, 8'd0,   8'd127, 0, 1'b0, 7,  10,   485, 2,  12'hFF0, 2};
        vecs[6] = '{10'd630, 10'd10,  8'd80,  8'd0,   0, 1'b0, 7,  640,  10,  2,  12'hFF0, 2};
        vecs[7] = '{10'd130, 10'd100, 8'd0,   8'd0,   0, 1'b1, 3,  130,  100, 0,  12'hF00, 1};
        vecs[8] = '{10'd200, 10'd200, 8'hE0,  8'hF0,  0, 1'b1, 35, 168,  184, 16, 12'h0F0, 17};
        vecs[9] = '{10'd50,  10'd60,  8'd1,   8'd3,   1, 1'b0, 52, 51,   63,  16, 12'h0F0, 34};

        Reset_n = 1'b0;
        frame_start = 1'b0;
        X = '0; Y = '0; x_vec = '0; y_vec = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset map_req", int'(map_req), 0);
        check("reset busy", int'(busy), 0);
        check("reset hit_valid", int'(hit_valid), 0);
        check("reset hitX", int'(hitX), 0);
        check("reset hitY", int'(hitY), 0);
        check("reset hit_steps", int'(hit_steps), 0);
        check("reset hit_color", int'(hit_color), 0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            apply_vec(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // frame_start during a march is ignored: same single result.
        apply_vec(vecs[0], 10, "refire");

        // Reset in cycle 8 of a march.
        wall_en = 1'b0;
        ack_delay = 0;
        X = 10'd100; Y = 10'd100; x_vec = 8'd64; y_vec = 8'd0;
        frame_start = 1'b1;
        @(posedge Clk);
        #1 frame_start = 1'b0;
        repeat (7) @(posedge Clk);
        #1 Reset_n = 1'b0;
        check("midreset busy before", int'(busy), 1);
        @(posedge Clk);
        @(negedge Clk);
        check("midreset map_req", int'(map_req), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset hit_valid", int'(hit_valid), 0);
        check("midreset hitX", int'(hitX), 0);
        check("midreset hitY", int'(hitY), 0);
        check("midreset hit_steps", int'(hit_steps), 0);
        check("midreset hit_color", int'(hit_color), 0);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        apply_vec(vecs[1], 0, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
